// File: rtl/serial_unit_dispatcher.sv
// Dispatches one decoded operation to the ALU, shifter or multiplier over a bit-serial link
// and returns the collected serial result through a valid/ready response.
module serial_unit_dispatcher #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        req_op_i,
  input  logic [DATA_W-1:0] req_a_i,
  input  logic [DATA_W-1:0] req_b_i,
  output logic              tx_data_o,
  output logic              alu_tx_valid_o,
  output logic              shf_tx_valid_o,
  output logic              mul_tx_valid_o,
  input  logic              alu_rx_data_i,
  input  logic              shf_rx_data_i,
  input  logic              mul_rx_data_i,
  input  logic              alu_rx_valid_i,
  input  logic              shf_rx_valid_i,
  input  logic              mul_rx_valid_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_lo_o,
  output logic [DATA_W-1:0] resp_hi_o,
  output logic              resp_err_o
);

  localparam int unsigned PktW = 2 * DATA_W + 3;
  localparam int unsigned ShW  = $clog2(DATA_W);
  localparam int unsigned ResW = 2 * DATA_W;
  localparam int unsigned PcW  = $clog2(PktW + 1);
  localparam int unsigned RcW  = $clog2(ResW);
  localparam int unsigned IcW  = $clog2(TIMEOUT + 1);

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpAnd = 3'd1;
  localparam logic [2:0] OpOr  = 3'd2;
  localparam logic [2:0] OpMul = 3'd3;
  localparam logic [2:0] OpShl = 3'd4;
  localparam logic [2:0] OpShr = 3'd5;

  typedef enum logic [1:0] {StIdle, StSend, StWait, StResp} state_e;
  typedef enum logic [1:0] {UnitAlu, UnitShf, UnitMul, UnitNone} unit_e;

  state_e            state_q, state_d;
  unit_e             unit_q, unit_d, req_unit;
  logic [PktW-1:0]   pkt_q, pkt_d, req_pkt;
  logic [PcW-1:0]    pcnt_q, pcnt_d, req_len;
  logic [ResW-1:0]   res_q, res_d;
  logic [RcW-1:0]    rcnt_q, rcnt_d, rlast;
  logic [IcW-1:0]    idle_q, idle_d;
  logic [DATA_W-1:0] lo_q, lo_d, hi_q, hi_d;
  logic              err_q, err_d;
  logic              rx_bit, rx_vld;

  // Packet layout puts op_code in the low bits so it leaves first.
  always_comb begin
    req_unit = UnitNone;
    req_len  = '0;
    req_pkt  = '0;
    case (req_op_i)
      OpAdd, OpAnd, OpOr: begin
        req_unit = UnitAlu;
        req_len  = PcW'(PktW);
        req_pkt  = {req_b_i, req_a_i, req_op_i};
      end
      OpShl, OpShr: begin
        req_unit = UnitShf;
        req_len  = PcW'(DATA_W + 3 + ShW);
        req_pkt  = {{(PktW - DATA_W - 3 - ShW){1'b0}}, req_b_i[ShW-1:0], req_a_i, req_op_i};
      end
      OpMul: begin
        req_unit = UnitMul;
        req_len  = PcW'(2 * DATA_W);
        req_pkt  = {3'b000, req_b_i, req_a_i};
      end
      default: ;
    endcase
  end

  always_comb begin
    rx_bit = 1'b0;
    rx_vld = 1'b0;
    case (unit_q)
      UnitAlu: begin rx_bit = alu_rx_data_i; rx_vld = alu_rx_valid_i; end
      UnitShf: begin rx_bit = shf_rx_data_i; rx_vld = shf_rx_valid_i; end
      UnitMul: begin rx_bit = mul_rx_data_i; rx_vld = mul_rx_valid_i; end
      default: ;
    endcase
  end

  assign rlast = (unit_q == UnitMul) ? RcW'(ResW - 1) : RcW'(DATA_W - 1);

  always_comb begin
    state_d = state_q;
    unit_d  = unit_q;
    pkt_d   = pkt_q;
    pcnt_d  = pcnt_q;
    res_d   = res_q;
    rcnt_d  = rcnt_q;
    idle_d  = idle_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          unit_d = req_unit;
          pkt_d  = req_pkt;
          pcnt_d = req_len;
          res_d  = '0;
          rcnt_d = '0;
          idle_d = '0;
          if (req_unit == UnitNone) begin
            state_d = StResp;
            err_d   = 1'b1;
            lo_d    = '0;
            hi_d    = '0;
          end else begin
            state_d = StSend;
          end
        end
      end
      StSend: begin
        pkt_d  = pkt_q >> 1;
        pcnt_d = pcnt_q - 1'b1;
        if (pcnt_q == PcW'(1)) state_d = StWait;
      end
      StWait: begin
        if (rx_vld) begin
          res_d[rcnt_q] = rx_bit;
          rcnt_d        = rcnt_q + 1'b1;
          idle_d        = '0;
          if (rcnt_q == rlast) begin
            state_d = StResp;
            err_d   = 1'b0;
            lo_d    = res_d[DATA_W-1:0];
            hi_d    = (unit_q == UnitMul) ? res_d[ResW-1:DATA_W] : '0;
          end
        end else begin
          idle_d = idle_q + 1'b1;
          if (idle_q == IcW'(TIMEOUT - 1)) begin
            state_d = StResp;
            err_d   = 1'b1;
            lo_d    = '0;
            hi_d    = '0;
          end
        end
      end
      StResp: begin
        if (resp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      unit_q  <= UnitNone;
      pkt_q   <= '0;
      pcnt_q  <= '0;
      res_q   <= '0;
      rcnt_q  <= '0;
      idle_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unit_q  <= unit_d;
      pkt_q   <= pkt_d;
      pcnt_q  <= pcnt_d;
      res_q   <= res_d;
      rcnt_q  <= rcnt_d;
      idle_q  <= idle_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o    = (state_q == StIdle);
  assign tx_data_o      = (state_q == StSend) & pkt_q[0];
  assign alu_tx_valid_o = (state_q == StSend) && (unit_q == UnitAlu);
  assign shf_tx_valid_o = (state_q == StSend) && (unit_q == UnitShf);
  assign mul_tx_valid_o = (state_q == StSend) && (unit_q == UnitMul);
  assign resp_valid_o   = (state_q == StResp);
  assign resp_lo_o      = lo_q;
  assign resp_hi_o      = hi_q;
  assign resp_err_o     = err_q;

endmodule

// File: doc/serial_unit_dispatcher.md
Name: serial_unit_dispatcher

Overview:
- Sequences the serial execution units (ALU, barrel shifter, multiplier) for the mini serial processor.
- Accepts one decoded operation with two 32-bit operands and builds the matching unit packet (ALU: op_2|op_1|op_code; shifter: shift_amount|op|op_code; multiplier: op_2|op_1).
- Shifts the packet out serially LSB-first, so op_code leaves first, then collects the serial result and returns it through a valid/ready response.
- Sits between the processor control FSM and the three units; only one operation is in flight at a time.

Parameters:
- TIMEOUT, 256, max idle cycles in WAIT between result bits before aborting with error (must be >=1)
- DATA_W, 32, operand/result width (REGISTER_SIZE)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  dispatcher can accept a request
- req_op  in  3  Operation code (ADD..SW encoding)
- req_a  in  32  operand 1
- req_b  in  32  operand 2; shifter uses req_b[4:0] as shift_amount
- tx_data  out  1  shared serial packet bit to units
- alu_tx_valid / shf_tx_valid / mul_tx_valid  out  1 each  tx_data is valid for that unit
- alu_rx_data / shf_rx_data / mul_rx_data  in  1 each  serial result bit from unit
- alu_rx_valid / shf_rx_valid / mul_rx_valid  in  1 each  result bit valid
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accepts response
- resp_lo  out  32  result (MUL: low word)
- resp_hi  out  32  MUL high word; 0 for other ops
- resp_err  out  1  unsupported op (LW/SW) or timeout

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE; req_ready=1; all tx_valid=0; tx_data=0; resp_valid=0; resp_lo=resp_hi=0; resp_err=0; all counters cleared.
- Reset mid-operation: state returns to IDLE on the next edge, tx_valid drops immediately at that edge, and partial results are discarded.
- Unit selection and packet width:
  - ADD/AND/OR -> ALU, 67 bits.
  - SHL/SHR -> shifter, 40 bits.
  - MUL -> multiplier, 64 bits.
  - Result width: 32 bits for ALU/shifter, 64 for MUL.
- IDLE: req_ready=1. On req_valid&&req_ready, latch the request, load the packet shift register and bit counter.
  - LW/SW: go to RESP with resp_err=1, result 0; no tx_valid is asserted.
  - Otherwise go to SEND.
- SEND: starts the cycle after acceptance.
  - Each cycle: tx_data=packet[0], the selected unit's tx_valid=1, others 0; shift right, decrement counter.
  - After the last bit go to WAIT. Total SEND duration = packet width cycles, with no gaps.
- WAIT: the selected unit's rx bit is sampled when its rx_valid=1, shifted in LSB-first. rx_valid from non-selected units is ignored.
  - The idle counter clears on every accepted bit and increments otherwise.
  - When the idle counter reaches TIMEOUT: go to RESP with resp_err=1, resp_lo=resp_hi=0.
  - After the last result bit: go to RESP with err=0. resp_valid rises the cycle after the last bit.
- RESP: resp_valid=1 and outputs stay stable until resp_ready=1.
  - On handshake: resp_valid=0 and state=IDLE next cycle; req_ready=1 again in that cycle.
  - A new request cannot be accepted in the same cycle as the response handshake.
- req_ready=0 in SEND/WAIT/RESP; req_valid in those states is ignored and must be held by the requester.
- Minimum ADD latency, acceptance to resp_valid: 1 + 67 + 32 cycles (unit responding back-to-back, no extra unit latency).

Test Plan:
- ADD a=5, b=7 -> alu_tx_valid high exactly 67 cycles; first 3 tx bits 0,0,0 (op 0), next 32 bits =5 LSB-first; model returns 12 -> resp_lo=12, resp_hi=0, err=0; shf/mul tx_valid never high.
- MUL a=0xFFFFFFFF, b=2 -> mul_tx_valid 64 cycles, no op_code bits sent; model returns 0x1_FFFFFFFE -> resp_hi=1, resp_lo=0xFFFFFFFE.
- SHL a=0x1, b=36 -> 40-bit packet, op bits 0,0,1 then a, then shift_amount=4; returns 0x10 -> resp_lo=0x10.
- LW and SW requests -> resp_valid 1 cycle after acceptance, err=1, result 0; no tx_valid ever asserted.
- ADD where the unit sends 10 bits then goes silent with TIMEOUT=8 -> resp_err=1 exactly 8 idle cycles after bit 10; spurious mul_rx_valid pulses in WAIT are ignored.
- Response backpressure: hold resp_ready=0 for 5 cycles -> resp outputs stable, req_ready=0. Reset asserted at SEND bit 20 -> all tx_valid=0 and req_ready=1 after the edge; the next ADD completes correctly.
